// File: rtl/prog_fir_coeffs_pkg.sv
// Shared constants for the ping-pong FIR coefficient store: register map,
// register bit positions, read latency and the swap FSM state type.
package prog_fir_coeffs_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_CLR_ERR = 1;

  localparam int STAT_ACTIVE  = 0;
  localparam int STAT_PENDING = 1;
  localparam int STAT_WR_ERR  = 2;
  localparam int STAT_CNT_LSB = 16;
  localparam int SWAP_CNT_W   = 16;

  localparam int RD_LAT       = 2;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } swap_state_e;

endpackage

// File: rtl/prog_fir_coeffs_bank.sv
// One coefficient bank: simple-dual-port RAM with a byte-masked write port
// and a read port registered twice (primitive output, then core output).
module prog_fir_coeffs_bank #(
  parameter int AW     = 10,
  parameter int COEF_W = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [COEF_W/8-1:0] be,
  input  logic [AW-1:0]       waddr,
  input  logic [COEF_W-1:0]   wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [COEF_W-1:0]   rdata
);

  logic [COEF_W-1:0] mem [2**AW];
  logic [COEF_W-1:0] rd_q;

  // RAM contents and read registers carry no reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < COEF_W/8; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rd_q <= mem[raddr];
    rdata <= rd_q;
  end

endmodule

// File: rtl/prog_fir_coeffs_pingpong.sv
// Double-buffered FIR coefficient store: the CPU fills the shadow bank, and an
// armed swap makes it the active bank atomically at the next frame_sync.
module prog_fir_coeffs_pingpong
  import prog_fir_coeffs_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int N_TAPS = 256,
  parameter int COEF_W = 32,
  parameter int CH_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  parameter int TAP_W  = $clog2(N_TAPS),
  parameter int ADDR_W = CH_W + TAP_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_en,
  input  logic                cpu_we,
  input  logic [COEF_W/8-1:0] cpu_be,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [COEF_W-1:0]   cpu_wr_data,
  output logic [COEF_W-1:0]   cpu_rd_data,
  output logic                cpu_rd_valid,
  input  logic                frame_sync,
  input  logic                coef_rd_en,
  input  logic [CH_W-1:0]     coef_chan,
  input  logic [TAP_W-1:0]    coef_tap,
  output logic [COEF_W-1:0]   coef_data,
  output logic                coef_valid,
  output logic                active_bank,
  output logic                swap_done
);

  localparam int AW = ADDR_W - 1;

  swap_state_e           state, next_state;
  logic                  swap;
  logic                  pending;
  logic                  wr_err;
  logic [SWAP_CNT_W-1:0] swap_cnt;

  logic                  reg_sel, cpu_wr, cpu_rd, coef_wr, ctrl_wr, arm, clr_err;
  logic [AW-1:0]         ram_addr, fab_addr;
  logic [COEF_W-1:0]     reg_rdata;
  logic [COEF_W-1:0]     bank_rdata [2];

  logic [RD_LAT-1:0]     fab_vld_sr, fab_sel_sr;
  logic [RD_LAT-1:0]     cpu_vld_sr, cpu_sel_sr, cpu_reg_sr;
  logic [COEF_W-1:0]     cpu_regval_sr [RD_LAT];
  logic [COEF_W-1:0]     coef_hold, cpu_hold;

  assign reg_sel  = cpu_addr[ADDR_W-1];
  assign ram_addr = cpu_addr[AW-1:0];
  assign fab_addr = {coef_chan, coef_tap};
  assign cpu_wr   = cpu_en & cpu_we;
  assign cpu_rd   = cpu_en & ~cpu_we;
  assign coef_wr  = cpu_wr & ~reg_sel;
  assign ctrl_wr  = cpu_wr & reg_sel & (ram_addr == AW'(REG_CTRL));
  assign arm      = ctrl_wr & cpu_wr_data[CTRL_ARM];
  assign clr_err  = ctrl_wr & cpu_wr_data[CTRL_CLR_ERR];
  assign pending  = (state == ST_PENDING);

  // An arm seen in IDLE only moves to PENDING, so a same-cycle frame_sync cannot swap.
  always_comb begin
    next_state = state;
    swap       = 1'b0;
    case (state)
      ST_IDLE:    if (arm) next_state = ST_PENDING;
      ST_PENDING: if (frame_sync) begin
                    next_state = ST_IDLE;
                    swap       = 1'b1;
                  end
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      active_bank <= 1'b0;
      swap_done   <= 1'b0;
      swap_cnt    <= '0;
      wr_err      <= 1'b0;
    end else begin
      state     <= next_state;
      swap_done <= swap;
      if (swap) begin
        active_bank <= ~active_bank;
        swap_cnt    <= swap_cnt + 1'b1;
      end
      if (coef_wr && pending) wr_err <= 1'b1;
      else if (clr_err)       wr_err <= 1'b0;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (ram_addr == AW'(REG_STATUS)) begin
      reg_rdata[STAT_ACTIVE]                 = active_bank;
      reg_rdata[STAT_PENDING]                = pending;
      reg_rdata[STAT_WR_ERR]                 = wr_err;
      reg_rdata[STAT_CNT_LSB +: SWAP_CNT_W]  = swap_cnt;
    end
  end

  // Each bank's read port belongs to the fabric while active and to the CPU while shadow.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_active;
    assign is_active = (active_bank == 1'(b));

    prog_fir_coeffs_bank #(
      .AW     (AW),
      .COEF_W (COEF_W)
    ) u_bank (
      .clk   (clk),
      .we    (coef_wr & ~pending & ~is_active),
      .be    (cpu_be),
      .waddr (ram_addr),
      .wdata (cpu_wr_data),
      .re    (is_active ? coef_rd_en : (cpu_rd & ~reg_sel)),
      .raddr (is_active ? fab_addr : ram_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Bank choice is captured with each request so a swap never redirects data in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fab_vld_sr <= '0;
      fab_sel_sr <= '0;
      cpu_vld_sr <= '0;
      cpu_sel_sr <= '0;
      cpu_reg_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) cpu_regval_sr[i] <= '0;
      coef_hold  <= '0;
      cpu_hold   <= '0;
    end else begin
      fab_vld_sr <= {fab_vld_sr[RD_LAT-2:0], coef_rd_en};
      fab_sel_sr <= {fab_sel_sr[RD_LAT-2:0], active_bank};
      cpu_vld_sr <= {cpu_vld_sr[RD_LAT-2:0], cpu_rd};
      cpu_sel_sr <= {cpu_sel_sr[RD_LAT-2:0], ~active_bank};
      cpu_reg_sr <= {cpu_reg_sr[RD_LAT-2:0], reg_sel};
      for (int i = RD_LAT-1; i > 0; i--) cpu_regval_sr[i] <= cpu_regval_sr[i-1];
      cpu_regval_sr[0] <= reg_rdata;
      coef_hold  <= coef_data;
      cpu_hold   <= cpu_rd_data;
    end
  end

  assign coef_valid   = fab_vld_sr[RD_LAT-1];
  assign cpu_rd_valid = cpu_vld_sr[RD_LAT-1];

  // Outputs hold between reads, since a bank's output register is shared by both sides.
  always_comb begin
    coef_data   = coef_hold;
    cpu_rd_data = cpu_hold;
    if (fab_vld_sr[RD_LAT-1]) coef_data = bank_rdata[fab_sel_sr[RD_LAT-1]];
    if (cpu_vld_sr[RD_LAT-1]) begin
      cpu_rd_data = cpu_reg_sr[RD_LAT-1] ? cpu_regval_sr[RD_LAT-1]
                                         : bank_rdata[cpu_sel_sr[RD_LAT-1]];
    end
  end

endmodule

// File: tb/tb_prog_fir_coeffs_pingpong.sv
// Directed self-checking bench for prog_fir_coeffs_pingpong: swap timing,
// write hazards, byte enables, read latency and mid-stream reset.
module tb_prog_fir_coeffs_pingpong;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en, cpu_we;
  logic [3:0]  cpu_be;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wr_data, cpu_rd_data;
  logic        cpu_rd_valid;
  logic        frame_sync, coef_rd_en;
  logic [1:0]  coef_chan;
  logic [7:0]  coef_tap;
  logic [31:0] coef_data;
  logic        coef_valid, active_bank, swap_done;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] OLD_V = 32'h0BAD_0000;
  localparam logic [31:0] NEW_V = 32'h2222_2222;

  prog_fir_coeffs_pingpong dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_en       (cpu_en),
    .cpu_we       (cpu_we),
    .cpu_be       (cpu_be),
    .cpu_addr     (cpu_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .frame_sync   (frame_sync),
    .coef_rd_en   (coef_rd_en),
    .coef_chan    (coef_chan),
    .coef_tap     (coef_tap),
    .coef_data    (coef_data),
    .coef_valid   (coef_valid),
    .active_bank  (active_bank),
    .swap_done    (swap_done)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] coef_addr(input int ch, input int tap);
    return {1'b0, 2'(ch), 8'(tap)};
  endfunction

  function automatic logic [10:0] reg_addr(input int idx);
    return {1'b1, 10'(idx)};
  endfunction

  // Stimulus helpers: all start and end on a falling edge.
  task automatic cpu_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wr_data = d; cpu_be = be;
    @(negedge clk);
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
  endtask

  task automatic cpu_read(input logic [10:0] a, output logic [31:0] d, output logic v1, output logic v2);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    cpu_en = 1'b0;
    v1 = cpu_rd_valid;
    @(negedge clk);
    v2 = cpu_rd_valid;
    d  = cpu_rd_data;
  endtask

  task automatic fab_read(input int ch, input int tap, output logic [31:0] d, output logic v1, output logic v2);
    coef_rd_en = 1'b1; coef_chan = 2'(ch); coef_tap = 8'(tap);
    @(negedge clk);
    coef_rd_en = 1'b0;
    v1 = coef_valid;
    @(negedge clk);
    v2 = coef_valid;
    d  = coef_data;
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v1, v2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (coef_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_coef_valid: got %b want 0", coef_valid); end
    vectors++; if (cpu_rd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cpu_rd_valid: got %b want 0", cpu_rd_valid); end
    vectors++; if (active_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_active_bank: got %b want 0", active_bank); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_swap_done: got %b want 0", swap_done); end
    vectors++; if (coef_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_coef_data: got %h want 0", coef_data); end
    vectors++; if (cpu_rd_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_cpu_rd_data: got %h want 0", cpu_rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (v1 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_status_early_valid: got %b want 0", v1); end
    vectors++; if (v2 !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_status_valid: got %b want 1", v2); end
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_status: got %h want 00000000", d); end
  endtask

  task automatic test_swap_basic();
    logic [31:0] d; logic v1, v2;
    cpu_write(coef_addr(1, 5), 32'hA5A5_0001, 4'hF);
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    @(negedge clk);
    pulse_fs();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("[TB] FAIL swap_done_pulse: got %b want 1", swap_done); end
    vectors++; if (active_bank !== 1'b1) begin miscompares++; $display("[TB] FAIL swap_active_bank: got %b want 1", active_bank); end
    @(negedge clk);
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("[TB] FAIL swap_done_single: got %b want 0", swap_done); end
    fab_read(1, 5, d, v1, v2);
    vectors++; if (v1 !== 1'b0) begin miscompares++; $display("[TB] FAIL swap_fab_early_valid: got %b want 0", v1); end
    vectors++; if (v2 !== 1'b1) begin miscompares++; $display("[TB] FAIL swap_fab_valid: got %b want 1", v2); end
    vectors++; if (d !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL swap_fab_data: got %h want a5a50001", d); end
    @(negedge clk);
    vectors++; if (coef_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_valid: got %b want 0", coef_valid); end
    vectors++; if (coef_data !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL hold_data: got %h want a5a50001", coef_data); end
    cpu_write(coef_addr(1, 5), OLD_V, 4'hF);
    cpu_read(coef_addr(1, 5), d, v1, v2);
    vectors++; if (d !== OLD_V) begin miscompares++; $display("[TB] FAIL shadow_readback: got %h want %h", d, OLD_V); end
  endtask

  task automatic test_arm_no_sync();
    logic [31:0] d; logic v1, v2;
    do_reset();
    cpu_write(coef_addr(1, 5), NEW_V, 4'hF);
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    repeat (100) @(negedge clk);
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0000_0002) begin miscompares++; $display("[TB] FAIL armed_status: got %h want 00000002", d); end
    fab_read(1, 5, d, v1, v2);
    vectors++; if (d !== OLD_V) begin miscompares++; $display("[TB] FAIL armed_fab_old: got %h want %h", d, OLD_V); end
    vectors++; if (active_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL armed_active_bank: got %b want 0", active_bank); end
  endtask

  task automatic test_arm_same_cycle();
    logic [31:0] d; logic v1, v2;
    do_reset();
    frame_sync = 1'b1;
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    frame_sync = 1'b0;
    @(negedge clk);
    vectors++; if (active_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL same_cycle_no_swap: got %b want 0", active_bank); end
    vectors++; if (swap_done !== 1'b0) begin miscompares++; $display("[TB] FAIL same_cycle_no_done: got %b want 0", swap_done); end
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0000_0002) begin miscompares++; $display("[TB] FAIL same_cycle_pending: got %h want 00000002", d); end
    pulse_fs();
    vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("[TB] FAIL next_sync_done: got %b want 1", swap_done); end
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0001_0001) begin miscompares++; $display("[TB] FAIL next_sync_status: got %h want 00010001", d); end
    fab_read(1, 5, d, v1, v2);
    vectors++; if (d !== NEW_V) begin miscompares++; $display("[TB] FAIL next_sync_fab_new: got %h want %h", d, NEW_V); end
  endtask

  task automatic test_write_while_pending();
    logic [31:0] d; logic v1, v2;
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    cpu_write(coef_addr(1, 5), 32'hDEAD_BEEF, 4'hF);
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0001_0007) begin miscompares++; $display("[TB] FAIL wr_err_set: got %h want 00010007", d); end
    cpu_read(coef_addr(1, 5), d, v1, v2);
    vectors++; if (d !== OLD_V) begin miscompares++; $display("[TB] FAIL dropped_write: got %h want %h", d, OLD_V); end
    cpu_write(reg_addr(0), 32'h2, 4'hF);
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0001_0003) begin miscompares++; $display("[TB] FAIL wr_err_clear: got %h want 00010003", d); end
    pulse_fs();
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0002_0000) begin miscompares++; $display("[TB] FAIL second_swap_status: got %h want 00020000", d); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic v1, v2;
    cpu_write(coef_addr(2, 0), 32'hFFFF_FFFF, 4'hF);
    cpu_write(coef_addr(2, 0), 32'h1234_5678, 4'b0010);
    cpu_read(coef_addr(2, 0), d, v1, v2);
    vectors++; if (v2 !== 1'b1) begin miscompares++; $display("[TB] FAIL be_valid: got %b want 1", v2); end
    vectors++; if (d !== 32'hFFFF_56FF) begin miscompares++; $display("[TB] FAIL be_merge: got %h want ffff56ff", d); end
    cpu_read(reg_addr(0), d, v1, v2);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL ctrl_reads_zero: got %h want 00000000", d); end
    cpu_read(reg_addr(7), d, v1, v2);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped_zero: got %h want 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v1, v2;
    logic [31:0] exp_q [4];
    exp_q = '{OLD_V, OLD_V, NEW_V, NEW_V};
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    coef_chan = 2'd1; coef_tap = 8'd5;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        vectors++; if (coef_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid[%0d]: got %b want 1", i-2, coef_valid); end
        vectors++; if (coef_data !== exp_q[i-2]) begin miscompares++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i-2, coef_data, exp_q[i-2]); end
      end
      if (i == 2) begin
        vectors++; if (swap_done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_swap_done: got %b want 1", swap_done); end
      end
      coef_rd_en = (i < 4);
      frame_sync = (i == 1);
      @(negedge clk);
    end
    vectors++; if (active_bank !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_active_bank: got %b want 1", active_bank); end
    cpu_write(reg_addr(0), 32'h1, 4'hF);
    coef_rd_en = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (coef_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_valid: got %b want 1", coef_valid); end
    rst_n = 1'b0;
    coef_rd_en = 1'b0;
    #1;
    vectors++; if (coef_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b want 0", coef_valid); end
    vectors++; if (active_bank !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_active_bank: got %b want 0", active_bank); end
    vectors++; if (coef_data !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_coef_data: got %h want 0", coef_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(reg_addr(1), d, v1, v2);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_arm_lost: got %h want 00000000", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wr_data = '0;
    frame_sync = 1'b0; coef_rd_en = 1'b0; coef_chan = '0; coef_tap = '0;
    @(negedge clk);
    test_reset();
    test_swap_basic();
    test_arm_no_sync();
    test_arm_same_cycle();
    test_write_while_pending();
    test_byte_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
